out_port_demux: RTL and testbench

- Parametrised, registered successor to the 1-to-4 output demux.
- Decodes MCU OUT transactions (PORT_ID, OUT_PORT, IO_STRB) onto N_CH output channels, each holding the last byte written to it.
- Each channel has a valid/ack handshake with its consumer, plus a sticky overrun flag.
- Adds broadcast and overrun-clear port addresses.
- Sits between the MCU output bus and peripheral consumers (LEDs, 7-seg, UART TX, ...).

---
 rtl/out_port_demux_pkg.sv | 32 +++
 rtl/out_demux_chan.sv | 63 ++++++
 rtl/out_port_demux.sv | 69 ++++++
 tb/tb_out_port_demux.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/out_port_demux_pkg.sv
// ============================================================================
// Module   : out_port_demux_pkg
// Purpose  : Shared types and derived port-ID helpers for the output demux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package out_port_demux_pkg;

  // Widest channel the shared state struct can carry.
  localparam int unsigned C_MAX_DATA_W = 32;

  typedef struct packed {
    logic [C_MAX_DATA_W-1:0] data;
    logic                    valid;
    logic                    wr_pulse;
    logic                    overrun;
  } chan_state_t;

  function automatic int unsigned bcast_id(input int unsigned base_id,
                                           input int unsigned n_ch);
    return base_id + n_ch;
  endfunction

  function automatic int unsigned ovclr_id(input int unsigned base_id,
                                           input int unsigned n_ch);
    return base_id + n_ch + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/out_demux_chan.sv
// ============================================================================
// Module   : out_demux_chan
// Purpose  : One output channel: data register, valid/ack handshake, sticky overrun.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_demux_chan
  import out_port_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr,
  input  logic              ack,
  input  logic [DATA_W-1:0] din,
  input  logic              ovr_clr,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              wr_pulse,
  output logic              overrun
);

  if (DATA_W > C_MAX_DATA_W) begin : g_bad_width
    $error("out_demux_chan: DATA_W exceeds C_MAX_DATA_W");
  end

  chan_state_t r_state;
  chan_state_t w_next;

  always_comb begin
    w_next          = r_state;
    w_next.wr_pulse = wr;
    if (wr) begin
      w_next.data  = C_MAX_DATA_W'(din);
      w_next.valid = 1'b1;
    end else if (ack) begin
      w_next.valid = 1'b0;
    end
    // A fresh overrun wins over a clear arriving in the same cycle.
    w_next.overrun = (wr & r_state.valid & ~ack) | (r_state.overrun & ~ovr_clr);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= '0;
    end else begin
      r_state <= w_next;
    end
  end

  assign data     = r_state.data[DATA_W-1:0];
  assign valid    = r_state.valid;
  assign wr_pulse = r_state.wr_pulse;
  assign overrun  = r_state.overrun;

  logic w_unused_data;
  assign w_unused_data = ^r_state.data;

endmodule

`default_nettype wire

// File: rtl/out_port_demux.sv
// ============================================================================
// Module   : out_port_demux
// Purpose  : Decodes MCU OUT transactions onto N_CH registered output channels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_port_demux
  import out_port_demux_pkg::*;
#(
  parameter int unsigned          DATA_W  = 8,
  parameter int unsigned          ID_W    = 8,
  parameter int unsigned          N_CH    = 4,
  parameter logic [ID_W-1:0]      BASE_ID = ID_W'('h40)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IO_STRB,
  input  logic [ID_W-1:0]          PORT_ID,
  input  logic [DATA_W-1:0]        OUT_PORT,
  input  logic [N_CH-1:0]          CH_ACK,
  output logic [N_CH*DATA_W-1:0]   CH_DATA,
  output logic [N_CH-1:0]          CH_VALID,
  output logic [N_CH-1:0]          CH_WR_PULSE,
  output logic [N_CH-1:0]          OVERRUN
);

  localparam logic [ID_W-1:0] c_bcast_id = ID_W'(bcast_id(32'(BASE_ID), N_CH));
  localparam logic [ID_W-1:0] c_ovclr_id = ID_W'(ovclr_id(32'(BASE_ID), N_CH));

  if (N_CH < 1 || N_CH > DATA_W) begin : g_bad_nch
    $error("out_port_demux: N_CH must be in 1..DATA_W");
  end

  if (64'(ovclr_id(32'(BASE_ID), N_CH)) > ((64'd1 << ID_W) - 64'd1)) begin : g_bad_ids
    $error("out_port_demux: OVCLR_ID does not fit in ID_W");
  end

  logic w_ovclr_hit;
  assign w_ovclr_hit = IO_STRB && (PORT_ID == c_ovclr_id);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam logic [ID_W-1:0] c_ch_id = ID_W'(32'(BASE_ID) + k);

    logic w_wr;
    logic w_ovr_clr;

    assign w_wr      = IO_STRB && ((PORT_ID == c_ch_id) || (PORT_ID == c_bcast_id));
    assign w_ovr_clr = w_ovclr_hit && OUT_PORT[k];

    out_demux_chan #(
      .DATA_W (DATA_W)
    ) u_chan (
      .CLK      (CLK),
      .RST      (RST),
      .wr       (w_wr),
      .ack      (CH_ACK[k]),
      .din      (OUT_PORT),
      .ovr_clr  (w_ovr_clr),
      .data     (CH_DATA[k*DATA_W +: DATA_W]),
      .valid    (CH_VALID[k]),
      .wr_pulse (CH_WR_PULSE[k]),
      .overrun  (OVERRUN[k])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_out_port_demux.sv
// ============================================================================
// Module   : tb_out_port_demux
// Purpose  : Self-checking bench for out_port_demux against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_out_port_demux;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IO_STRB = 1'b0;
  logic [7:0]  PORT_ID = '0;
  logic [7:0]  OUT_PORT = '0;
  logic [3:0]  CH_ACK = '0;
  logic [31:0] CH_DATA;
  logic [3:0]  CH_VALID;
  logic [3:0]  CH_WR_PULSE;
  logic [3:0]  OVERRUN;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_data [4];
  logic [3:0] m_valid = '0;
  logic [3:0] m_pulse = '0;
  logic [3:0] m_ovr   = '0;

  out_port_demux dut (
    .CLK         (CLK),
    .RST         (RST),
    .IO_STRB     (IO_STRB),
    .PORT_ID     (PORT_ID),
    .OUT_PORT    (OUT_PORT),
    .CH_ACK      (CH_ACK),
    .CH_DATA     (CH_DATA),
    .CH_VALID    (CH_VALID),
    .CH_WR_PULSE (CH_WR_PULSE),
    .OVERRUN     (OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [31:0] exp_data;
    for (int k = 0; k < 4; k++) exp_data[k*8 +: 8] = m_data[k];
    checks++;
    assert (CH_DATA === exp_data) else begin
      errors++;
      $error("FAIL %s ch_data observed=%h expected=%h", tag, CH_DATA, exp_data);
    end
    chk4({tag, " valid"},    CH_VALID,    m_valid);
    chk4({tag, " wr_pulse"}, CH_WR_PULSE, m_pulse);
    chk4({tag, " overrun"},  OVERRUN,     m_ovr);
  endtask

  // One bus cycle: drive, clock, advance the model by the channel rules, check.
  task automatic step(input logic rst, input logic strb, input logic [7:0] id,
                      input logic [7:0] d, input logic [3:0] ack, input string tag);
    logic hit, set;
    @(negedge CLK);
    RST = rst; IO_STRB = strb; PORT_ID = id; OUT_PORT = d; CH_ACK = ack;
    @(posedge CLK);
    if (rst) begin
      for (int k = 0; k < 4; k++) m_data[k] = 8'h00;
      m_valid = '0; m_pulse = '0; m_ovr = '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        hit = strb && ((id == 8'h40 + k) || (id == 8'h44));
        set = hit && m_valid[k] && !ack[k];
        if (strb && id == 8'h45 && d[k]) m_ovr[k] = 1'b0;
        if (set) m_ovr[k] = 1'b1;
        m_pulse[k] = hit;
        if (hit) begin
          m_data[k]  = d;
          m_valid[k] = 1'b1;
        end else if (ack[k]) begin
          m_valid[k] = 1'b0;
        end
      end
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    logic [7:0] id;
    logic [3:0] ack;
    int unsigned r;
    for (int k = 0; k < 4; k++) m_data[k] = 8'h00;

    step(1'b1, 1'b1, 8'h40, 8'hAA, 4'h0, "reset_with_strobe");
    chk4("reset valid const", CH_VALID, 4'b0000);
    step(1'b0, 1'b0, 8'h40, 8'hAA, 4'h0, "idle_after_reset");

    step(1'b0, 1'b1, 8'h42, 8'h5C, 4'h0, "write_ch2");
    chk4("ch2 valid const", CH_VALID, 4'b0100);
    chk4("ch2 pulse const", CH_WR_PULSE, 4'b0100);
    step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, "ch2_pulse_drop");
    chk4("ch2 pulse gone", CH_WR_PULSE, 4'b0000);
    step(1'b0, 1'b0, 8'h00, 8'h00, 4'b0100, "ack_ch2");
    chk4("ch2 acked", CH_VALID, 4'b0000);

    step(1'b0, 1'b1, 8'h41, 8'h11, 4'h0, "ch1_first");
    step(1'b0, 1'b1, 8'h41, 8'h22, 4'h0, "ch1_overrun");
    chk4("ch1 overrun const", OVERRUN, 4'b0010);
    step(1'b0, 1'b1, 8'h45, 8'h02, 4'h0, "clear_ch1");
    step(1'b0, 1'b1, 8'h41, 8'h33, 4'b0010, "ch1_write_with_ack");
    chk4("write+ack no overrun", OVERRUN, 4'b0000);

    step(1'b0, 1'b1, 8'h43, 8'h77, 4'h0, "ch3_load");
    step(1'b0, 1'b1, 8'h44, 8'hF0, 4'h0, "broadcast");
    chk4("bcast pulse const", CH_WR_PULSE, 4'hF);
    chk4("bcast overrun const", OVERRUN, 4'b1010);
    step(1'b0, 1'b1, 8'h45, 8'h08, 4'h0, "clear_ch3");
    chk4("clear ch3 const", OVERRUN, 4'b0010);

    step(1'b0, 1'b1, 8'h3F, 8'h99, 4'h0, "id_below_range");
    step(1'b0, 1'b1, 8'h46, 8'h99, 4'h0, "id_above_range");
    step(1'b0, 1'b0, 8'h41, 8'h99, 4'h0, "no_strobe");

    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 9);
      id  = (r < 8) ? 8'(8'h3F + r) : 8'($urandom);
      ack = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), id,
           8'($urandom), ack, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
